// File: rtl/ponto_fixo_mult_seq_ctrl.sv
// Sequential unsigned fixed-point multiplier: N shift-and-add iterations on one
// 2N-bit adder, then round-half-up, scale by NFRAC and optionally saturate.
module ponto_fixo_mult_seq_ctrl #(
    parameter int N        = 8,
    parameter int NFRAC    = 3,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   p_raw,
    output logic [N-1:0]     p_qm_n,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

    localparam int                CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
    localparam logic [2*N-1:0]    ONE      = 1;
    // Half an LSB of the scaled result; rounding adds it before the shift.
    localparam logic [2*N-1:0]    HALF     = (NFRAC == 0) ? '0
                                           : ONE << ((NFRAC == 0) ? 0 : NFRAC - 1);

    state_t           state;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   mcand;
    logic [N-1:0]     mplier;
    logic [CNT_W-1:0] cnt;

    logic [2*N-1:0]   rounded;
    logic [2*N-1:0]   scaled;
    logic             scaled_ovf;

    assign rounded    = acc + HALF;
    assign scaled     = rounded >> NFRAC;
    assign scaled_ovf = |scaled[2*N-1:N];

    // in_ready depends on rst_n directly so it drops during reset without a cycle of lag.
    assign in_ready = rst_n && (state == IDLE);

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            p_raw     <= '0;
            p_qm_n    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{N{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= ROUND;
                end
                ROUND: begin
                    overflow  <= scaled_ovf;
                    p_qm_n    <= (scaled_ovf && SATURATE) ? '1 : scaled[N-1:0];
                    p_raw     <= acc;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ponto_fixo_mult_seq_ctrl.md
Name: ponto_fixo_mult_seq_ctrl

Overview:
- Sequential, area-reduced counterpart of the team's combinational unsigned fixed-point multiplier.
- An FSM runs one 2N-bit adder for N shift-and-add iterations, then rounds, scales and optionally saturates to Q(N-NFRAC).NFRAC.
- Operands enter and results leave through valid/ready handshakes. The block sits between a register-file or stream source and any consumer of N-bit fixed-point products.

Parameters:
- N, 8, operand and result width in bits (N >= 2).
- NFRAC, 3, fractional bits of operands and result (0 <= NFRAC < N).
- SATURATE, 1, 1 = clamp result to all-ones on overflow; 0 = truncate to scaled[N-1:0].

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept operands; high only in IDLE with rst_n high.
- a  input  N  multiplicand, unsigned fixed-point; sampled only on accept.
- b  input  N  multiplier, unsigned fixed-point; sampled only on accept.
- out_valid  output  1  result registers hold a new result.
- out_ready  input  1  consumer accepts the result.
- p_raw  output  2N  full-precision product a*b, before rounding.
- p_qm_n  output  N  rounded, scaled, saturated or truncated result.
- overflow  output  1  scaled result does not fit in N bits.
- busy  output  1  high in CALC or ROUND.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - p_raw, p_qm_n, overflow, out_valid, busy all become 0.
  - Internal acc, mcand, mplier and cnt are cleared.
  - in_ready is 0 while rst_n is low.
  - Reset aborts any operation in progress; no out_valid is produced for the aborted operation.
- States: IDLE, CALC, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - Accept is in_valid & in_ready at an edge. On accept: mcand <= zero-extended a (2N bits), mplier <= b, acc <= 0, cnt <= 0, go to CALC.
- CALC, exactly N cycles:
  - Each edge: if mplier[0], acc <= acc + mcand (2N-bit ripple add, modulo 2^2N; cannot wrap for unsigned N-bit operands).
  - Each edge: mcand <= mcand << 1, mplier <= mplier >> 1, cnt <= cnt + 1.
  - When cnt == N-1, go to ROUND.
- ROUND, 1 cycle:
  - rounded = acc + (NFRAC==0 ? 0 : 2^(NFRAC-1)), in 2N bits.
  - scaled = rounded >> NFRAC.
  - overflow <= |scaled[2N-1:N].
  - p_qm_n <= (overflow && SATURATE) ? all-ones : scaled[N-1:0].
  - p_raw <= acc.
  - out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1. Result outputs are held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready: out_valid <= 0, go to IDLE.
  - p_raw, p_qm_n and overflow keep their last values after the handshake until the next ROUND or reset.
- Latency: out_valid rises N+1 edges after the accept edge (9 for N=8).
- Throughput: one operation per N+3 cycles when in_valid and out_ready are held high.
- Simultaneous events:
  - in_valid during DONE together with out_ready: the new operand is not accepted until the following IDLE cycle.
  - out_ready outside DONE has no effect.
- Operand changes after accept do not affect the result.

Test Plan:
1. Basic multiply, N=8, NFRAC=3: a=0x10 (2.0), b=0x18 (3.0) -> p_raw=0x0180, p_qm_n=0x30, overflow=0; out_valid high exactly 9 edges after accept, busy high for 9 cycles.
2. Round-up: a=0x03, b=0x05 -> p_raw=0x000F, p_qm_n=0x02.
3. Round-down: a=0x09, b=0x09 -> p_raw=0x0051, p_qm_n=0x0A.
4. Overflow:
   - a=0xFF, b=0xFF, SATURATE=1 -> p_raw=0xFE01, overflow=1, p_qm_n=0xFF.
   - Same operands, SATURATE=0 instance -> p_qm_n=0xC0, overflow=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands.
   - out_valid stays 1, outputs stay constant, in_ready stays 0, new operands are not accepted.
   - out_ready=1 -> IDLE next cycle, then the new operands are accepted.
6. Reset mid-operation: drive rst_n low for one edge at the 4th CALC cycle.
   - All outputs become 0, and no out_valid ever appears for that operation.
   - in_ready returns to 1 once rst_n is high.
   - Next op a=0x00, b=0xFF -> all-zero result, overflow=0.
   - Then in_valid and out_ready held high: successive accepts every 11 cycles.
